iir_stim_capture: RTL
=====================

IIR_STIM_CAPTURE -- requirements
Module: iir_stim_capture

Interface
REQ-001 Parameter DATA_W, default 24: sample width, signed two's complement.
REQ-002 Parameter DEPTH, default 2048: stimulus and capture buffer depth, power of two; AW = log2(DEPTH).
REQ-003 Parameter DRAIN_TIMEOUT, default 4096: maximum DRAIN cycles without a result before abort.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle run request.
REQ-007 num_samples  in  AW+1  number of samples to play, 0..DEPTH; sampled on the accepted start.
REQ-008 ld_en, ld_addr[AW], ld_data[DATA_W]  in  stimulus buffer write port.
REQ-009 dut_data  out  DATA_W  stimulus sample to the filter under test.
REQ-010 dut_valid  out  1  stimulus qualifier.
REQ-011 res_data  in  DATA_W  filter output.
REQ-012 res_valid  in  1  result qualifier.
REQ-013 cap_addr  in  AW; cap_data  out  DATA_W  capture buffer read port.
REQ-014 busy, done, timeout_err  out  1 each  status outputs.
REQ-015 cycle_cnt  out  32  cycles spent in RUN plus DRAIN.
REQ-016 first_lat  out  16  cycles from the first dut_valid to the first res_valid.
REQ-017 res_count  out  AW+1  results received, saturating.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 Accepted start: start=1 in IDLE or DONE; clears done, timeout_err, cycle_cnt, first_lat, res_count and the read pointer.
REQ-020 Accepted start with num_samples=0 goes directly to DONE on the next cycle and never asserts dut_valid.
REQ-021 Accepted start with num_samples>0 goes to RUN; start while busy=1 is ignored.
REQ-022 RUN: dut_data/dut_valid are registered; one sample per issue slot, taken from buffer addresses 0..num_samples-1 in order.
REQ-023 The first dut_valid occurs 2 cycles after the accepted start (1 cycle of RAM read plus 1 output register).
REQ-024 After the last sample is issued, the FSM enters DRAIN and dut_valid drops on the following cycle.
REQ-025 The capture buffer stores each res_valid sample at address res_count; results arriving when res_count >= DEPTH are dropped; res_count saturates at DEPTH.
REQ-026 res_valid is honoured in RUN and DRAIN and ignored in IDLE and DONE.
REQ-027 DRAIN ends and DONE is entered when res_count = num_samples.
REQ-028 DRAIN also ends in DONE, with timeout_err=1, after DRAIN_TIMEOUT cycles with no res_valid; the idle counter restarts on every res_valid.
REQ-029 busy = 1 in RUN and DRAIN; done = 1 in DONE and held until the next accepted start.
REQ-030 cycle_cnt increments in RUN and DRAIN and wraps at 2^32.
REQ-031 first_lat counts from the first dut_valid, freezes at the first res_valid, and saturates at 0xFFFF.
REQ-032 cap_data has 1-cycle read latency and is readable in any state.
REQ-033 ld_en is honoured only when busy=0; if ld_en and start are asserted in the same cycle, the load completes first and playback sees the new data.

Reset
REQ-034 rst_n=0: state = IDLE; dut_valid, busy, done and timeout_err are 0; dut_data, cycle_cnt, first_lat and res_count are 0.
REQ-035 Buffer contents are not reset.
REQ-036 Reset asserted mid-run aborts immediately with no further dut_valid.

Configuration
REQ-037 Macro STIM_GAP_EN defined: adds input gap_cycles[8]; issue slots are spaced gap_cycles+1 cycles apart, with dut_valid=0 in the gaps; gap_cycles is sampled on start.
REQ-038 Macro STIM_GAP_EN undefined: no gap_cycles port; one sample is issued every cycle.

Structure
REQ-039 Shared package iir_pkg holds DATA_W_DEF, DEPTH_DEF, DRAIN_TIMEOUT_DEF and the FSM state enum type.
REQ-040 One sub-module, iir_sample_ram: simple dual-port RAM (1 write, 1 read, 1-cycle registered read), instantiated twice: stimulus and capture.

Verification
REQ-041 Load ramp 0..7, num_samples=8, loopback res=dut delayed 5 cycles -> capture holds 0..7, first_lat=5, done=1, timeout_err=0.
REQ-042 num_samples=0, start -> done=1 on the next cycle, dut_valid never asserted, res_count=0.
REQ-043 No results returned, DRAIN_TIMEOUT=16 -> timeout_err=1 and done=1 exactly 16 cycles after DRAIN is entered.
REQ-044 STIM_GAP_EN defined, gap_cycles=2, 4 samples -> dut_valid is high on cycles 0, 3, 6 and 9 after the first issue.
REQ-045 start re-pulsed mid-RUN -> ignored, run completes normally; rst_n pulsed mid-RUN -> busy=0 and dut_valid=0 immediately.
REQ-046 DEPTH=8, loopback emitting 10 results -> capture holds the first 8, res_count=8.

Source files
------------

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared definitions for the IIR stimulus/capture harness:
//               parameter defaults and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    localparam int DATA_W_DEF        = 24;
    localparam int DEPTH_DEF         = 2048;
    localparam int DRAIN_TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } iir_state_t;

endpackage
`default_nettype wire

// File: rtl/iir_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : iir_sample_ram
// Description : Simple dual-port sample RAM, one write port and one read
//               port with a registered (1-cycle) read. Contents not reset.
// Ports       : clk                         - clock
//               wr_en, wr_addr, wr_data     - write port
//               rd_addr, rd_data            - read port (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sample_ram
    import iir_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/iir_stim_capture.sv
`default_nettype none
// ============================================================================
// Module      : iir_stim_capture
// Description : Plays a preloaded stimulus buffer into a filter under test
//               and captures the returned results, with run statistics.
//               Optional macro STIM_GAP_EN adds gap_cycles, spacing issue
//               slots gap_cycles+1 cycles apart.
// Ports       : clk, rst_n (async, active-low)
//               start, num_samples             - run request
//               ld_en, ld_addr, ld_data        - stimulus buffer load
//               gap_cycles (STIM_GAP_EN only)  - idle cycles between samples
//               dut_data, dut_valid            - stimulus to the filter
//               res_data, res_valid            - filter result
//               cap_addr, cap_data             - capture buffer readback
//               busy, done, timeout_err        - status
//               cycle_cnt, first_lat, res_count- statistics
// Revision    : 1.0 - initial release
// ============================================================================
module iir_stim_capture
    import iir_pkg::*;
#(
    parameter  int DATA_W        = DATA_W_DEF,
    parameter  int DEPTH         = DEPTH_DEF,
    parameter  int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       num_samples,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef STIM_GAP_EN
    input  logic [7:0]        gap_cycles,
`endif
    output logic [DATA_W-1:0] dut_data,
    output logic              dut_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    input  logic [AW-1:0]     cap_addr,
    output logic [DATA_W-1:0] cap_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [31:0]       cycle_cnt,
    output logic [15:0]       first_lat,
    output logic [AW:0]       res_count
);

    localparam logic [AW:0] c_depth        = (AW+1)'(DEPTH);
    localparam logic [31:0] c_timeout_last = 32'(DRAIN_TIMEOUT - 1);

    iir_state_t        r_state;
    logic [AW:0]       r_num;
    logic [AW:0]       r_rd_ptr;
    logic              r_rd_vld;      // RAM read in flight this cycle
    logic              r_rd_last;     // that read is the final sample
    logic [AW:0]       r_res_count;
    logic [31:0]       r_idle_cnt;
    logic              r_lat_started;
    logic              r_lat_frozen;
    logic [DATA_W-1:0] w_stim_q;
    logic              w_busy;
    logic              w_accept;
    logic              w_slot_open;
    logic              w_issue;
    logic              w_cap_we;

`ifdef STIM_GAP_EN
    logic [7:0]        r_gap;
    logic [7:0]        r_gap_cnt;
    assign w_slot_open = (r_gap_cnt == 8'd0);
`else
    assign w_slot_open = 1'b1;
`endif

    assign w_busy   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_issue  = (r_state == ST_RUN) && (r_rd_ptr != r_num) && w_slot_open;
    // Results beyond the capture depth are dropped and the count saturates.
    assign w_cap_we = w_busy && res_valid && (r_res_count < c_depth);

    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign res_count = r_res_count;

    // Loads are blocked while busy; a load coinciding with start still lands
    // before the first read, which happens one cycle after the accept.
    iir_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_stim_ram (
        .clk     (clk),
        .wr_en   (ld_en && !w_busy),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_data (w_stim_q)
    );

    iir_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cap_ram (
        .clk     (clk),
        .wr_en   (w_cap_we),
        .wr_addr (r_res_count[AW-1:0]),
        .wr_data (res_data),
        .rd_addr (cap_addr),
        .rd_data (cap_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_num         <= '0;
            r_rd_ptr      <= '0;
            r_rd_vld      <= 1'b0;
            r_rd_last     <= 1'b0;
            dut_valid     <= 1'b0;
            dut_data      <= '0;
            r_res_count   <= '0;
            r_idle_cnt    <= '0;
            cycle_cnt     <= '0;
            first_lat     <= '0;
            r_lat_started <= 1'b0;
            r_lat_frozen  <= 1'b0;
            timeout_err   <= 1'b0;
`ifdef STIM_GAP_EN
            r_gap         <= '0;
            r_gap_cnt     <= '0;
`endif
        end else begin
            // Two-stage issue pipeline: RAM read, then output register.
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && (r_rd_ptr == r_num - 1'b1);
            dut_valid <= r_rd_vld;
            if (r_rd_vld) begin
                dut_data <= w_stim_q;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
`ifdef STIM_GAP_EN
            if (w_issue) begin
                r_gap_cnt <= r_gap;
            end else if (r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
`endif
            if (w_busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (w_cap_we) begin
                r_res_count <= r_res_count + 1'b1;
            end
            // Latency counts cycles from the first dut_valid until the
            // first result is seen, then holds.
            if (w_busy && !r_lat_frozen) begin
                if (res_valid) begin
                    r_lat_frozen <= 1'b1;
                end else if (dut_valid || r_lat_started) begin
                    r_lat_started <= 1'b1;
                    if (first_lat != 16'hFFFF) begin
                        first_lat <= first_lat + 16'd1;
                    end
                end
            end
            if ((r_state == ST_DRAIN) && !res_valid) begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end else begin
                r_idle_cnt <= '0;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_num         <= num_samples;
                        r_rd_ptr      <= '0;
                        r_res_count   <= '0;
                        cycle_cnt     <= '0;
                        first_lat     <= '0;
                        r_lat_started <= 1'b0;
                        r_lat_frozen  <= 1'b0;
                        timeout_err   <= 1'b0;
`ifdef STIM_GAP_EN
                        r_gap         <= gap_cycles;
                        r_gap_cnt     <= '0;
`endif
                        r_state       <= (num_samples == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // DRAIN starts on the edge that presents the last sample.
                    if (r_rd_vld && r_rd_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_res_count == r_num) begin
                        r_state <= ST_DONE;
                    end else if (!res_valid && (r_idle_cnt == c_timeout_last)) begin
                        r_state     <= ST_DONE;
                        timeout_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
